// File: rtl/sine_pwm_pkg.sv
// Shared types and default sizing for the sine PWM sequencer and its helpers.
package sine_pwm_pkg;

  localparam int unsigned DefAddrW   = 6;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefDivW    = 16;
  localparam int unsigned TableDepth = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/sine_tick_divider.sv
// Programmable tick divider: counts 0..div-1 while enabled, pulses tc on terminal count.
module sine_tick_divider #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  localparam logic [DIV_W-1:0] One = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // div must be non-zero; the owner clamps it.
  always_comb begin
    tc    = en && (cnt_q == (div - One));
    cnt_d = '0;
    if (en && !tc) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sine_pwm_sequencer.sv
// Walks the sine ROM at a programmable tick and applies samples on PWM period boundaries.
// Define SINE_PWM_CYCLE_COUNT_EN to add the saturating cycle_count output.
module sine_pwm_sequencer
  import sine_pwm_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DIV_W  = DefDivW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div_val,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              period_end,
  output logic [DATA_W-1:0] width_out,
  output logic              busy,
`ifdef SINE_PWM_CYCLE_COUNT_EN
  output logic [15:0]       cycle_count,
`endif
  output logic              overrun
);

  localparam logic [DIV_W-1:0]  DivOne  = DIV_W'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rom_en_q, rom_en_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   pend_val_q, pend_val_d;
  logic [DATA_W-1:0]   width_q, width_d;
  logic                overrun_q, overrun_d;
  logic                div_en;
  logic                tc;
  logic                apply;
  logic                last_fetch;

  assign div_en = (state_q != StIdle);

  sine_tick_divider #(
    .DIV_W(DIV_W)
  ) u_tick_divider (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .div  (div_q),
    .tc   (tc)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    last_fetch = rom_en_q && (addr_q == AddrMax);

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StRun;
          div_d   = (div_val == '0) ? DivOne : div_val;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (start) begin
          state_d = StRun;
        end else if (last_fetch) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A terminal count on the drain-exit clock must not start a new fetch.
    rom_en_d = tc && (state_d != StIdle);
    addr_d   = rom_en_q ? (addr_q + AddrOne) : addr_q;

    // On a simultaneous capture and period_end the old sample is applied, so nothing is lost.
    apply      = period_end && pend_q;
    pend_d     = rom_en_q || (pend_q && !apply);
    pend_val_d = rom_en_q ? rom_data : pend_val_q;
    width_d    = apply ? pend_val_q : width_q;
    overrun_d  = overrun_q || (rom_en_q && pend_q && !period_end);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= DivOne;
      addr_q     <= '0;
      rom_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      width_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      addr_q     <= addr_d;
      rom_en_q   <= rom_en_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      width_q    <= width_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef SINE_PWM_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else if (last_fetch && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign cycle_count = cycle_cnt_q;
`endif

  assign rom_addr  = addr_q;
  assign rom_en    = rom_en_q;
  assign width_out = width_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule
